lcd_spi_tx_fifo: RTL and testbench

Parametrised successor to the single-word LCD SPI writer. It buffers {dc, data} words in an internal FIFO and serialises them MSB-first to the panel. Configurable data width, FIFO depth, SCLK divider, idle clock polarity and inter-frame CS gap. It sits between the init and show-pic sequencers and the panel pins. Back-to-back words are sent as one CS-low burst.

---
 rtl/lcd_spi_tx_fifo.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_spi_tx_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_tx_fifo.sv
// lcd_spi_tx_fifo: buffers {dc,payload} words and shifts them MSB-first onto the SPI LCD pins.
// Latency: a word pushed into an empty FIFO while idle is popped (cs low) on the next edge.
// Backpressure: full is registered; a push while full is dropped and latches overflow.
module lcd_spi_tx_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 2,
  parameter bit CPOL    = 1'b0,
  parameter int CS_GAP  = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [DATA_W:0]          wr_data,
  input  logic                     wr_en,
  input  logic                     flush,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     busy,
  output logic                     wr_done,
  output logic                     cs,
  output logic                     dc,
  output logic                     sclk,
  output logic                     mosi
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  // FIFO storage and bookkeeping
  logic [DATA_W:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             overflow_q;

  // Serialiser state and registered pin outputs
  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] sreg_rot;
  logic             flush_pend_q;
  logic             cs_q, dc_q, sclk_q, mosi_q, busy_q, wr_done_q;

  logic [DATA_W:0]  head;
  logic             push, pop, shift_end, fifo_nempty;

  assign head        = mem_q[rd_ptr_q];
  assign fifo_nempty = (level_q != '0);
  assign shift_end   = (state_q == SHIFT) &&
                       (div_cnt_q == DIV_W'(2 * CLK_DIV - 1)) &&
                       (bit_cnt_q == BIT_W'(DATA_W - 1));
  // A flush in the same cycle suppresses the pop so level lands on 0 cleanly.
  // Once flushed mid-word, the running word is the last one of the burst.
  assign pop  = !flush && fifo_nempty &&
                ((state_q == IDLE) || (shift_end && !flush_pend_q));
  assign push = wr_en && !full_q && !flush;

  assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  assign full_d  = (level_d == LVL_W'(DEPTH));

  // Rotate rather than shift so every register bit stays live; only the top bit is ever driven out.
  assign sreg_rot = (sreg_q << 1) | (sreg_q >> (DATA_W - 1));

  // FIFO storage write; contents need no reset because pointers gate every read
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, full flag and sticky overflow
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end
      if (flush) begin
        wr_ptr_q <= rd_ptr_q;
        level_q  <= '0;
        full_q   <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        level_q <= level_d;
        full_q  <= full_d;
      end
    end
  end

  // IDLE/SHIFT/GAP sequencer driving registered cs, dc, sclk, mosi, busy and wr_done
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      sreg_q       <= '0;
      flush_pend_q <= 1'b0;
      cs_q         <= 1'b1;
      dc_q         <= 1'b0;
      sclk_q       <= CPOL;
      mosi_q       <= 1'b0;
      busy_q       <= 1'b0;
      wr_done_q    <= 1'b0;
    end else begin
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            sreg_q       <= head[DATA_W-1:0];
            dc_q         <= head[DATA_W];
            mosi_q       <= head[DATA_W-1];
            cs_q         <= 1'b0;
            busy_q       <= 1'b1;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (flush) begin
            flush_pend_q <= 1'b1;
          end
          if (div_cnt_q == DIV_W'(CLK_DIV - 1)) begin
            // Mid-bit: drive sclk to its active level, data already stable
            sclk_q    <= ~CPOL;
            div_cnt_q <= div_cnt_q + 1'b1;
          end else if (div_cnt_q == DIV_W'(2 * CLK_DIV - 1)) begin
            // End of bit: sclk back to idle and data advances on the same edge
            sclk_q    <= CPOL;
            div_cnt_q <= '0;
            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
              wr_done_q <= 1'b1;
              if (pop) begin
                // Back-to-back word: keep cs low, reload without a gap
                sreg_q       <= head[DATA_W-1:0];
                dc_q         <= head[DATA_W];
                mosi_q       <= head[DATA_W-1];
                bit_cnt_q    <= '0;
                flush_pend_q <= 1'b0;
              end else begin
                cs_q         <= 1'b1;
                mosi_q       <= 1'b0;
                gap_cnt_q    <= '0;
                flush_pend_q <= 1'b0;
                state_q      <= GAP;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              sreg_q    <= sreg_rot;
              mosi_q    <= sreg_rot[DATA_W-1];
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        GAP: begin
          // cs held high; queued words wait until the gap has elapsed
          if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign wr_done  = wr_done_q;
  assign cs       = cs_q;
  assign dc       = dc_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_lcd_spi_tx_fifo.sv
// Bench for lcd_spi_tx_fifo: instance 0 is mode 0 with CLK_DIV=2, instance 1 is CPOL=1 with CLK_DIV=1.
// A timeline model (word start time plus arithmetic on elapsed cycles) predicts every output each cycle.
// Directed scenarios add literal expectations for timing, bit order, burst, overflow, reset and flush.
module tb_lcd_spi_tx_fifo;

  localparam int DW   = 8;
  localparam int DP   = 4;
  localparam int LW   = 3;
  localparam int GAPN = 2;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [1:0]        rst_n, wr_en, flush;
  logic [1:0][8:0]   wr_data;
  logic [1:0]        cs, dc, sclk, mosi, busy, wr_done, full, overflow;
  logic [1:0][LW-1:0] level;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  lcd_spi_tx_fifo #(.DATA_W(DW), .DEPTH(DP), .CLK_DIV(2), .CPOL(1'b0), .CS_GAP(GAPN)) u_a (
    .sys_clk(sys_clk), .sys_rst_n(rst_n[0]), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
    .flush(flush[0]), .full(full[0]), .level(level[0]), .overflow(overflow[0]),
    .busy(busy[0]), .wr_done(wr_done[0]), .cs(cs[0]), .dc(dc[0]), .sclk(sclk[0]), .mosi(mosi[0]));

  lcd_spi_tx_fifo #(.DATA_W(DW), .DEPTH(DP), .CLK_DIV(1), .CPOL(1'b1), .CS_GAP(GAPN)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(rst_n[1]), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
    .flush(flush[1]), .full(full[1]), .level(level[1]), .overflow(overflow[1]),
    .busy(busy[1]), .wr_done(wr_done[1]), .cs(cs[1]), .dc(dc[1]), .sclk(sclk[1]), .mosi(mosi[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] mf [2][8];   // queued words, head at index 0
  int         mcnt [2];    // queued word count
  int         mk   [2];    // cycles elapsed in current word, -1 when no word active
  int         mgap [2];    // gap cycles left
  logic [8:0] mw   [2];
  logic       mbusy [2], movf [2], mdone [2], mflp [2], mdc [2];

  function automatic int divof(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic cpolof(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset(input int i);
    mcnt[i] = 0; mk[i] = -1; mgap[i] = 0; mw[i] = '0;
    mbusy[i] = 1'b0; movf[i] = 1'b0; mdone[i] = 1'b0; mflp[i] = 1'b0; mdc[i] = 1'b0;
  endtask

  task automatic model_start(input int i);
    mw[i] = mf[i][0];
    for (int j = 0; j < 7; j++) mf[i][j] = mf[i][j+1];
    mcnt[i]--;
    mk[i] = 0; mdc[i] = mw[i][8]; mbusy[i] = 1'b1; mflp[i] = 1'b0;
  endtask

  task automatic model_step(input int i);
    int  pre  = mcnt[i];
    int  wlen = 2 * divof(i) * DW;
    bit  fl   = flush[i];
    bit  psh  = wr_en[i] && (pre < DP) && !fl;
    bit  want = 1'b0;
    if (wr_en[i] && pre == DP) movf[i] = 1'b1;
    mdone[i] = 1'b0;
    if (mk[i] >= 0) begin
      if (fl) mflp[i] = 1'b1;
      if (mk[i] + 1 == wlen) begin
        mdone[i] = 1'b1;
        if (pre > 0 && !fl && !mflp[i]) want = 1'b1;
        else begin mk[i] = -1; mgap[i] = GAPN; mflp[i] = 1'b0; end
      end else begin
        mk[i]++;
      end
    end else if (mgap[i] > 0) begin
      mgap[i]--;
      if (mgap[i] == 0) mbusy[i] = 1'b0;
    end else if (pre > 0 && !fl) begin
      want = 1'b1;
    end
    if (fl) begin
      mcnt[i] = 0;
    end else begin
      if (want) model_start(i);
      if (psh) begin mf[i][mcnt[i]] = wr_data[i]; mcnt[i]++; end
    end
  endtask

  // {cs, dc, sclk, mosi, busy, wr_done, full, overflow, level}
  function automatic logic [10:0] mexp(input int i);
    int   d = divof(i);
    logic s = cpolof(i);
    logic m = 1'b0;
    if (mk[i] >= 0) begin
      s = cpolof(i) ^ ((mk[i] % (2 * d)) >= d);
      m = mw[i][7 - mk[i] / (2 * d)];
    end
    return {(mk[i] < 0), mdc[i], s, m, mbusy[i], mdone[i], (mcnt[i] == DP), movf[i], LW'(mcnt[i])};
  endfunction

  always @(posedge sys_clk or negedge rst_n[0]) begin
    if (!rst_n[0]) model_reset(0); else model_step(0);
  end
  always @(posedge sys_clk or negedge rst_n[1]) begin
    if (!rst_n[1]) model_reset(1); else model_step(1);
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge sys_clk) begin
    logic [10:0] act;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        act = {cs[i], dc[i], sclk[i], mosi[i], busy[i], wr_done[i], full[i], overflow[i], level[i]};
        chk(i == 0 ? "cycle_a" : "cycle_b", 32'(act), 32'(mexp(i)));
      end
    end
  end

  // Bit capture at the active-going sclk edge; for CPOL=1 that is the falling edge
  logic [7:0] cap_a, cap_b;
  int         ncap_a, ncap_b;
  always @(posedge sclk[0]) if (rst_n[0] === 1'b1) begin cap_a = {cap_a[6:0], mosi[0]}; ncap_a++; end
  always @(negedge sclk[1]) if (rst_n[1] === 1'b1) begin cap_b = {cap_b[6:0], mosi[1]}; ncap_b++; end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  logic [8:0] bseq [3] = '{9'h02A, 9'h100, 9'h1FF};

  initial begin
    int nlow, first, last, nd;
    int dn [4];
    logic [2:0] dcs;
    rst_n = 2'b00; wr_en = 2'b00; flush = 2'b00; wr_data = '0;
    cap_a = '0; cap_b = '0; ncap_a = 0; ncap_b = 0;
    model_reset(0); model_reset(1);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_state_a", 32'({cs[0], dc[0], sclk[0], mosi[0], busy[0], wr_done[0], full[0], overflow[0], level[0]}), 32'h400);
    chk("reset_state_b", 32'({cs[1], dc[1], sclk[1], mosi[1], busy[1], wr_done[1], full[1], overflow[1], level[1]}), 32'h500);
    @(negedge sys_clk);
    rst_n = 2'b11;
    tick();
    chk_en = 1'b1;
    tick();

    // Single word 9'h136
    ncap_a = 0; cap_a = '0;
    wr_data[0] = 9'h136; wr_en[0] = 1'b1;
    tick();                                   // E0
    wr_en[0] = 1'b0;
    chk("t1_level_e0", 32'(level[0]), 1);
    chk("t1_cs_e0", 32'(cs[0]), 1);
    tick();                                   // E1
    chk("t1_cs_e1", 32'(cs[0]), 0);
    chk("t1_dc_e1", 32'(dc[0]), 1);
    chk("t1_busy_e1", 32'(busy[0]), 1);
    repeat (31) tick();                       // E32
    chk("t1_cs_e32", 32'(cs[0]), 0);
    tick();                                   // E33
    chk("t1_cs_e33", 32'(cs[0]), 1);
    chk("t1_done_e33", 32'(wr_done[0]), 1);
    tick();                                   // E34
    chk("t1_busy_e34", 32'(busy[0]), 1);
    chk("t1_done_e34", 32'(wr_done[0]), 0);
    tick();                                   // E35
    chk("t1_busy_e35", 32'(busy[0]), 0);
    chk("t1_bits", 32'(cap_a), 32'h36);
    chk("t1_nbits", 32'(ncap_a), 8);

    // Burst of three words on consecutive cycles
    nlow = 0; first = -1; last = -1; nd = 0; dcs = '0;
    for (int r = 0; r <= 110; r++) begin
      wr_en[0]   = (r < 3);
      wr_data[0] = (r < 3) ? bseq[r] : 9'h000;
      tick();
      if (!cs[0]) begin nlow++; if (first < 0) first = r; last = r; end
      if (wr_done[0]) begin if (nd < 4) dn[nd] = r; nd++; end
      if (r == 1 || r == 33 || r == 65) dcs = {dcs[1:0], dc[0]};
    end
    chk("t2_cs_low_cycles", 32'(nlow), 96);
    chk("t2_cs_first", 32'(first), 1);
    chk("t2_cs_last", 32'(last), 96);
    chk("t2_done_count", 32'(nd), 3);
    chk("t2_done0", 32'(dn[0]), 33);
    chk("t2_done1", 32'(dn[1]), 65);
    chk("t2_done2", 32'(dn[2]), 97);
    chk("t2_dc_seq", 32'(dcs), 32'b011);

    // Overflow: wr_en held for six cycles into a 4-deep FIFO
    nd = 0;
    for (int r = 0; r < 200; r++) begin
      wr_en[0]   = (r < 6);
      wr_data[0] = 9'(9'h0F0 + r);
      tick();
      if (r == 4) begin
        chk("t3_full_e4", 32'(full[0]), 1);
        chk("t3_ovf_e4", 32'(overflow[0]), 0);
      end
      if (r == 5) begin
        chk("t3_full_e5", 32'(full[0]), 1);
        chk("t3_level_e5", 32'(level[0]), 4);
        chk("t3_ovf_e5", 32'(overflow[0]), 1);
      end
      if (wr_done[0]) nd++;
    end
    chk("t3_words_sent", 32'(nd), 5);
    chk("t3_ovf_sticky", 32'(overflow[0]), 1);

    // Asynchronous reset during bit 3 with two words queued
    for (int r = 0; r < 3; r++) begin
      wr_en[0] = 1'b1; wr_data[0] = 9'(9'h111 + r);
      tick();
    end
    wr_en[0] = 1'b0;
    repeat (11) tick();                       // E13, inside bit 3
    chk("t4_level_before", 32'(level[0]), 2);
    chk("t4_cs_before", 32'(cs[0]), 0);
    #2 rst_n[0] = 1'b0;
    #1;
    chk("t4_async_reset", 32'({cs[0], dc[0], sclk[0], mosi[0], busy[0], wr_done[0], full[0], overflow[0], level[0]}), 32'h400);
    @(negedge sys_clk);
    rst_n[0] = 1'b1;
    nd = 0;
    for (int r = 0; r < 80; r++) begin
      tick();
      if (wr_done[0]) nd++;
    end
    chk("t4_no_done", 32'(nd), 0);
    chk("t4_level_after", 32'(level[0]), 0);
    chk("t4_cs_after", 32'(cs[0]), 1);

    // Flush with a simultaneous push while a word shifts and three are queued
    nd = 0; first = -1;
    for (int r = 0; r <= 60; r++) begin
      wr_en[0]   = (r <= 4);
      wr_data[0] = (r < 4) ? 9'(9'h0C1 + r) : 9'h0EE;
      flush[0]   = (r == 4);
      tick();
      if (r == 3) chk("t5_level_pre", 32'(level[0]), 3);
      if (r == 4) begin
        chk("t5_level_flush", 32'(level[0]), 0);
        chk("t5_full_flush", 32'(full[0]), 0);
      end
      if (wr_done[0]) begin nd++; first = r; end
    end
    flush[0] = 1'b0; wr_en[0] = 1'b0;
    chk("t5_one_done", 32'(nd), 1);
    chk("t5_done_time", 32'(first), 33);
    chk("t5_cs_end", 32'(cs[0]), 1);
    chk("t5_busy_end", 32'(busy[0]), 0);

    // CPOL=1, CLK_DIV=1 instance: push 9'h0A5
    chk("t6_sclk_idle", 32'(sclk[1]), 1);
    ncap_b = 0; cap_b = '0; nlow = 0; first = -1; nd = 0;
    wr_data[1] = 9'h0A5; wr_en[1] = 1'b1;
    tick();
    wr_en[1] = 1'b0;
    for (int r = 1; r <= 30; r++) begin
      tick();
      if (!cs[1]) nlow++;
      if (wr_done[1]) begin nd++; first = r; end
    end
    chk("t6_word_cycles", 32'(nlow), 16);
    chk("t6_done_time", 32'(first), 17);
    chk("t6_done_count", 32'(nd), 1);
    chk("t6_bits", 32'(cap_b), 32'hA5);
    chk("t6_nbits", 32'(ncap_b), 8);
    chk("t6_sclk_after", 32'(sclk[1]), 1);

    repeat (4) tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
